// File: rtl/phase_sequence_monitor_pkg.sv
// Shared types for the three-phase cycle monitor: phase codes, FSM states,
// fault codes and the phase rotation helpers.
package phase_sequence_monitor_pkg;

    localparam int unsigned N_PH = 3;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_X    = 2'd1,
        PH_Y    = 2'd2,
        PH_Z    = 2'd3
    } phase_t;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_LOCKED,
        ST_FAULT
    } fsm_t;

    typedef enum logic [2:0] {
        ERR_NONE    = 3'd0,
        ERR_ORDER   = 3'd1,
        ERR_MULTI   = 3'd2,
        ERR_STATE   = 3'd3,
        ERR_TIMEOUT = 3'd4
    } err_t;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_X:    return PH_Y;
            PH_Y:    return PH_Z;
            PH_Z:    return PH_X;
            default: return PH_NONE;
        endcase
    endfunction

    // Only a one-hot edge vector maps to a phase; anything else is PH_NONE.
    function automatic phase_t rise_to_phase(input logic [N_PH-1:0] rise);
        case (rise)
            3'b001:  return PH_X;
            3'b010:  return PH_Y;
            3'b100:  return PH_Z;
            default: return PH_NONE;
        endcase
    endfunction

endpackage

// File: rtl/phase_sequence_monitor_if.sv
// Phase cycle bus between the clock divisor side (master) and the monitor (slave).
interface phase_sequence_monitor_if #(
    parameter int unsigned CNT_W = 16
);
    logic             cyclex;
    logic             cycley;
    logic             cyclez;
    logic [1:0]       state;
    logic             clear;
    logic             strobex;
    logic             strobey;
    logic             strobez;
    logic [1:0]       phase;
    logic             locked;
    logic             error;
    logic [2:0]       errcode;
    logic [CNT_W-1:0] rounds;

    modport master (
        output cyclex, cycley, cyclez, state, clear,
        input  strobex, strobey, strobez, phase, locked, error, errcode, rounds
    );

    modport slave (
        input  cyclex, cycley, cyclez, state, clear,
        output strobex, strobey, strobez, phase, locked, error, errcode, rounds
    );

endinterface

// File: rtl/phase_sequence_monitor_edge.sv
// Registers the three phase lines once, keeps the previous sample and
// produces the rising-edge vector plus a "more than one edge" flag.
module phase_edge_detect
    import phase_sequence_monitor_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [N_PH-1:0] lines,
    output logic [N_PH-1:0] rise,
    output logic            multi
);

    logic [N_PH-1:0] cur;
    logic [N_PH-1:0] prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= '0;
            prev <= '0;
        end else begin
            cur  <= lines;
            prev <= cur;
        end
    end

    assign rise  = cur & ~prev;
    assign multi = (rise[0] & rise[1]) | (rise[0] & rise[2]) | (rise[1] & rise[2]);

endmodule

// File: rtl/phase_sequence_monitor.sv
// Receives the X/Y/Z phase cycle, emits one-clock strobes, tracks lock to the
// X->Y->Z rotation, counts rotations and latches the first protocol fault.
module phase_sequence_monitor
    import phase_sequence_monitor_pkg::*;
#(
    parameter int unsigned LOCK_ROUNDS = 2,
    parameter int unsigned TIMEOUT     = 8,
    parameter int unsigned CNT_W       = 16
) (
    input logic                     i_CLOCK,
    input logic                     i_RESET,
    phase_sequence_monitor_if.slave bus
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned LK_W = $clog2(LOCK_ROUNDS + 1);

    logic [N_PH-1:0]  rise;
    logic             multi;
    logic [1:0]       state_q;
    logic [N_PH-1:0]  strobe;
    fsm_t             fsm;
    fsm_t             fsm_nx;
    phase_t           phase;
    phase_t           edge_ph;
    err_t             errcode;
    err_t             fault_code;
    logic             any_edge;
    logic             in_order;
    logic             lock_hit;
    logic             xy_seen;
    logic [TO_W-1:0]  idle_cnt;
    logic [LK_W-1:0]  lock_cnt;
    logic [CNT_W-1:0] rounds;

    phase_edge_detect u_edge (
        .clk   (i_CLOCK),
        .rst   (i_RESET),
        .lines ({bus.cyclez, bus.cycley, bus.cyclex}),
        .rise  (rise),
        .multi (multi)
    );

    always_comb begin
        any_edge = |rise;
        edge_ph  = rise_to_phase(rise);
        in_order = any_edge && !multi &&
                   ((phase == PH_NONE) || (edge_ph == next_phase(phase)));
        lock_hit = (fsm == ST_HUNT) && in_order && (edge_ph == PH_Z) && xy_seen &&
                   (lock_cnt == LK_W'(LOCK_ROUNDS - 1));
    end

    // Fault priority: MULTI > ORDER > STATE > TIMEOUT.
    always_comb begin
        fault_code = ERR_NONE;
        if (multi)
            fault_code = ERR_MULTI;
        else if (any_edge && !in_order)
            fault_code = ERR_ORDER;
        else if (state_q == 2'd0)
            fault_code = ERR_STATE;
        else if (!any_edge && (idle_cnt == TO_W'(TIMEOUT - 1)))
            fault_code = ERR_TIMEOUT;
    end

    always_ff @(posedge i_CLOCK) begin
        if (i_RESET)
            fsm <= ST_HUNT;
        else
            fsm <= fsm_nx;
    end

    always_comb begin
        fsm_nx = fsm;
        unique case (fsm)
            ST_HUNT:   if (lock_hit) fsm_nx = ST_LOCKED;
            ST_LOCKED: if (fault_code != ERR_NONE) fsm_nx = ST_FAULT;
            ST_FAULT:  if (bus.clear) fsm_nx = ST_HUNT;
            default:   fsm_nx = ST_HUNT;
        endcase
    end

    always_comb begin
        bus.locked  = (fsm == ST_LOCKED);
        bus.error   = (fsm == ST_FAULT);
        bus.strobex = strobe[0];
        bus.strobey = strobe[1];
        bus.strobez = strobe[2];
        bus.phase   = phase;
        bus.errcode = errcode;
        bus.rounds  = rounds;
    end

    always_ff @(posedge i_CLOCK) begin
        if (i_RESET) begin
            state_q  <= '0;
            strobe   <= '0;
            phase    <= PH_NONE;
            errcode  <= ERR_NONE;
            rounds   <= '0;
            idle_cnt <= '0;
            lock_cnt <= '0;
            xy_seen  <= 1'b0;
        end else begin
            state_q <= bus.state;
            strobe  <= (fsm == ST_FAULT) ? '0 : rise;

            // Counts in every state but saturates, so it only trips in LOCKED.
            if (any_edge)
                idle_cnt <= '0;
            else if (idle_cnt != TO_W'(TIMEOUT))
                idle_cnt <= idle_cnt + TO_W'(1);

            unique case (fsm)
                ST_HUNT: begin
                    if (in_order) begin
                        phase   <= edge_ph;
                        xy_seen <= (edge_ph == PH_Y) && (phase == PH_X);
                        if ((edge_ph == PH_Z) && xy_seen)
                            lock_cnt <= lock_hit ? '0 : lock_cnt + LK_W'(1);
                        if (lock_hit)
                            rounds <= '0;
                    end else if (any_edge) begin
                        phase    <= multi ? PH_NONE : edge_ph;
                        lock_cnt <= '0;
                        xy_seen  <= 1'b0;
                    end
                    if (bus.clear)
                        rounds <= '0;
                end
                ST_LOCKED: begin
                    if (fault_code != ERR_NONE) begin
                        errcode <= fault_code;
                    end else if (any_edge) begin
                        phase <= edge_ph;
                        if (edge_ph == PH_Z)
                            rounds <= rounds + CNT_W'(1);
                    end
                    if (bus.clear)
                        rounds <= '0;
                end
                ST_FAULT: begin
                    if (bus.clear) begin
                        errcode  <= ERR_NONE;
                        rounds   <= '0;
                        phase    <= PH_NONE;
                        lock_cnt <= '0;
                        xy_seen  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
